// File: rtl/max_group_sched.sv
// max_group_sched: gathers W-bit scores into groups of L and launches them into a fixed-latency max pipeline.
// Define MAX_GROUP_SCHED_STATS_EN to add the stat_groups / stat_stall counters.
`default_nettype none

module max_group_sched #(
   parameter int W     = 8,
   parameter int L     = 16,
   parameter int DEPTH = 4
) (
   input  logic           c,
   input  logic           r,
   input  logic [W-1:0]   in_d,
   input  logic           in_valid,
   input  logic           in_last,
   output logic           in_ready,
   output logic [L*W-1:0] mx_d,
   input  logic [W-1:0]   mx_q,
   output logic [W-1:0]   out_q,
   output logic           out_last,
   output logic           out_valid,
   input  logic           out_ready
`ifdef MAX_GROUP_SCHED_STATS_EN
   ,
   output logic [15:0]    stat_groups,
   output logic [15:0]    stat_stall
`endif
);

   localparam int GW = (L > 1) ? $clog2(L) : 1;
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [GW-1:0] GLAST    = GW'(L - 1);
   localparam logic [PW-1:0] PLAST    = PW'(DEPTH - 1);
   localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);

   typedef enum logic [1:0] {
      GATHER = 2'd0,
      LAUNCH = 2'd1,
      STALL  = 2'd2
   } state_t;

   state_t         state;
   logic [W-1:0]   gbuf [L];
   logic [GW-1:0]  gcnt;
   logic           last_flag;
   logic [L-2:0]   vpipe;
   logic [L-2:0]   lpipe;
   logic [CW-1:0]  credits;
   logic [W:0]     mem [DEPTH];
   logic [PW-1:0]  wptr;
   logic [PW-1:0]  rptr;
   logic [CW-1:0]  count;

   logic in_xfer;
   logic launch;
   logic pop;
   logic fifo_wr;

   assign in_ready = (state == GATHER) && !r;
   assign in_xfer  = in_valid && in_ready;
   assign launch   = (state == LAUNCH) && (credits != '0);
   assign pop      = out_valid && out_ready;
   assign fifo_wr  = vpipe[L-2];

   always_comb begin
      mx_d = '0;
      if (launch) begin
         for (int k = 0; k < L; k++) begin
            mx_d[k*W +: W] = gbuf[k];
         end
      end
   end

   // gbuf is zeroed after every launch so unused slots of a partial group pad with the unsigned minimum
   always_ff @(posedge c or posedge r) begin
      if (r) begin
         state     <= GATHER;
         gcnt      <= '0;
         last_flag <= 1'b0;
         for (int k = 0; k < L; k++) begin
            gbuf[k] <= '0;
         end
      end else begin
         case (state)
            GATHER: begin
               if (in_xfer) begin
                  gbuf[gcnt] <= in_d;
                  gcnt       <= gcnt + 1'b1;
                  if ((gcnt == GLAST) || in_last) begin
                     state     <= LAUNCH;
                     last_flag <= in_last;
                  end
               end
            end
            LAUNCH: begin
               if (launch) begin
                  state <= GATHER;
                  gcnt  <= '0;
                  for (int k = 0; k < L; k++) begin
                     gbuf[k] <= '0;
                  end
               end else begin
                  state <= STALL;
               end
            end
            STALL: begin
               if (credits != '0) begin
                  state <= LAUNCH;
               end
            end
            default: state <= GATHER;
         endcase
      end
   end

   // Valid/last tags ride alongside the L-1 cycle max pipeline
   always_ff @(posedge c or posedge r) begin
      if (r) begin
         vpipe <= '0;
         lpipe <= '0;
      end else begin
         vpipe[0] <= launch;
         lpipe[0] <= last_flag;
         for (int k = 1; k < L - 1; k++) begin
            vpipe[k] <= vpipe[k-1];
            lpipe[k] <= lpipe[k-1];
         end
      end
   end

   // A credit is reserved at launch and returned only when the result leaves the FIFO
   always_ff @(posedge c or posedge r) begin
      if (r) begin
         credits <= CRED_MAX;
      end else begin
         case ({launch, pop})
            2'b10:   credits <= credits - 1'b1;
            2'b01:   credits <= credits + 1'b1;
            default: credits <= credits;
         endcase
      end
   end

   always_ff @(posedge c or posedge r) begin
      if (r) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            mem[k] <= '0;
         end
      end else begin
         if (fifo_wr) begin
            mem[wptr] <= {lpipe[L-2], mx_q};
            wptr      <= (wptr == PLAST) ? '0 : wptr + 1'b1;
         end
         if (pop) begin
            rptr <= (rptr == PLAST) ? '0 : rptr + 1'b1;
         end
         case ({fifo_wr, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign out_valid = (count != '0);
   assign out_q     = out_valid ? mem[rptr][W-1:0] : '0;
   assign out_last  = out_valid & mem[rptr][W];

   always @(posedge c) begin
      if (!r) begin
         assert (!(fifo_wr && !pop && (count == CRED_MAX)));
      end
   end

`ifdef MAX_GROUP_SCHED_STATS_EN
   always_ff @(posedge c or posedge r) begin
      if (r) begin
         stat_groups <= '0;
         stat_stall  <= '0;
      end else begin
         if (launch && (stat_groups != 16'hFFFF)) begin
            stat_groups <= stat_groups + 16'd1;
         end
         if ((state == STALL) && (stat_stall != 16'hFFFF)) begin
            stat_stall <= stat_stall + 16'd1;
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_max_group_sched.sv
// tb_max_group_sched: table-driven groups with a result scoreboard, plus latency, reset, stall and toggle sequences.
`default_nettype none

module tb_max_group_sched;

   localparam int W     = 8;
   localparam int L     = 16;
   localparam int DEPTH = 4;
   localparam int BOUND = 400;

   logic           c;
   logic           r;
   logic [W-1:0]   in_d;
   logic           in_valid;
   logic           in_last;
   logic           in_ready;
   logic [L*W-1:0] mx_d;
   logic [W-1:0]   mx_q;
   logic [W-1:0]   out_q;
   logic           out_last;
   logic           out_valid;
   logic           out_ready;
`ifdef MAX_GROUP_SCHED_STATS_EN
   logic [15:0]    stat_groups;
   logic [15:0]    stat_stall;
`endif

   max_group_sched #(.W(W), .L(L), .DEPTH(DEPTH)) dut (
      .c         (c),
      .r         (r),
      .in_d      (in_d),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .mx_d      (mx_d),
      .mx_q      (mx_q),
      .out_q     (out_q),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef MAX_GROUP_SCHED_STATS_EN
      ,
      .stat_groups (stat_groups),
      .stat_stall  (stat_stall)
`endif
   );

   initial c = 1'b0;
   always #5 c = ~c;

   // Reference max pipeline: combinational max then L-1 register stages, no reset
   logic [W-1:0] mmax;
   logic [W-1:0] mp [L-1];
   always_comb begin
      mmax = '0;
      for (int k = 0; k < L; k++) begin
         if (mx_d[k*W +: W] > mmax) mmax = mx_d[k*W +: W];
      end
   end
   always @(posedge c) begin
      mp[0] <= mmax;
      for (int k = 1; k < L - 1; k++) mp[k] <= mp[k-1];
   end
   assign mx_q = mp[L-2];

   typedef struct {
      int         len;
      logic [7:0] base;
      logic [7:0] step;
      int         hot;
      logic [7:0] hot_val;
      bit         last;
      logic [7:0] exp_max;
      bit         exp_last;
   } vec_t;

   vec_t        tab [10];
   logic [8:0]  sb [$];
   int          nvec = 0;
   int          nerr = 0;
   int          or_mode = 0;

   always @(negedge c) begin
      case (or_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'b0;
         default: out_ready = ~out_ready;
      endcase
   end

   // Output monitor: scoreboard pops on transfer, hold-stability check while stalled
   logic       hold = 1'b0;
   logic [8:0] hval = '0;
   always @(negedge c) begin
      logic [8:0] e;
      #2;
      if (!r && out_valid) begin
         if (hold) begin
            nvec++;
            if ({out_last, out_q} !== hval) begin
               nerr++;
               $display("FAIL hold_stable got=%h required=%h", {out_last, out_q}, hval);
            end
         end
         if (out_ready) begin
            nvec++;
            if (sb.size() == 0) begin
               nerr++;
               $display("FAIL unexpected_result got=%h required=none", {out_last, out_q});
            end else begin
               e = sb.pop_front();
               if ({out_last, out_q} !== e) begin
                  nerr++;
                  $display("FAIL result got last=%b q=%h required last=%b q=%h", out_last, out_q, e[8], e[7:0]);
               end
            end
         end
      end
      hold = !r && out_valid && !out_ready;
      hval = {out_last, out_q};
   end

   task automatic chk(input string name, input int got, input int exp);
      nvec++;
      if (got != exp) begin
         nerr++;
         $display("FAIL %s got=%0h required=%0h", name, got, exp);
      end
   endtask

   task automatic send_elem(input logic [7:0] d, input logic l);
      int n;
      in_d = d; in_valid = 1'b1; in_last = l;
      n = 0;
      while (!in_ready && n < BOUND) begin
         @(negedge c);
         n++;
      end
      if (!in_ready) begin
         nvec++; nerr++;
         $display("FAIL in_ready_timeout got=0 required=1");
      end
      @(negedge c);
   endtask

   task automatic send_group(input vec_t v);
      int tmp;
      logic [7:0] d;
      for (int i = 0; i < v.len; i++) begin
         tmp = int'(v.base) + int'(v.step) * i;
         d = (i == v.hot) ? v.hot_val : tmp[7:0];
         send_elem(d, v.last && (i == v.len - 1));
      end
      in_valid = 1'b0; in_last = 1'b0;
      sb.push_back({v.exp_last, v.exp_max});
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 2000) begin
         @(negedge c);
         n++;
      end
      chk("drain_left", sb.size(), 0);
      repeat (3) @(negedge c);
   endtask

   task automatic timed_group(input vec_t v);
      int lat;
      lat = -1;
      send_group(v);
      chk("launch_in_ready", int'(in_ready), 0);
      for (int k = 1; k <= 40 && lat < 0; k++) begin
         @(negedge c);
         if (k == 1) chk("gather_in_ready", int'(in_ready), 1);
         if (out_valid) lat = k;
      end
      chk("latency", lat, L);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int full [6];
      logic [15:0] base_groups;
      tab[0] = '{16, 8'h00, 8'h01, -1, 8'h00, 1'b0, 8'h0F, 1'b0};
      tab[1] = '{16, 8'h00, 8'h01,  5, 8'hBE, 1'b0, 8'hBE, 1'b0};
      tab[2] = '{ 3, 8'h10, 8'h09,  1, 8'h7F, 1'b1, 8'h7F, 1'b1};
      tab[3] = '{ 1, 8'h5A, 8'h00, -1, 8'h00, 1'b1, 8'h5A, 1'b1};
      tab[4] = '{16, 8'hF0, 8'hFF, -1, 8'h00, 1'b1, 8'hF0, 1'b1};
      tab[5] = '{16, 8'h00, 8'h00, -1, 8'h00, 1'b0, 8'h00, 1'b0};
      tab[6] = '{16, 8'h80, 8'h07, 15, 8'hFF, 1'b0, 8'hFF, 1'b0};
      tab[7] = '{15, 8'h01, 8'h01,  0, 8'hFE, 1'b1, 8'hFE, 1'b1};
      tab[8] = '{ 2, 8'h33, 8'h11, -1, 8'h00, 1'b1, 8'h44, 1'b1};
      tab[9] = '{16, 8'h10, 8'h10, -1, 8'h00, 1'b0, 8'hF0, 1'b0};
      full = '{0, 1, 4, 5, 6, 9};

      r = 1'b1; in_d = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      repeat (2) @(negedge c);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_q", int'(out_q), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_mx_d", int'(mx_d != '0), 0);
      r = 1'b0;
      @(negedge c);
`ifdef MAX_GROUP_SCHED_STATS_EN
      chk("rst_stat_groups", int'(stat_groups), 0);
      chk("rst_stat_stall", int'(stat_stall), 0);
`endif

      timed_group(tab[0]);
      drain();
      timed_group(tab[1]);
      drain();

      for (int i = 2; i < 10; i++) send_group(tab[i]);
      drain();

      // Reset five cycles after a launch, with a partial group of 0xFF also pending
      send_group(tab[0]);
      @(negedge c);
      for (int i = 0; i < 3; i++) send_elem(8'hFF, 1'b0);
      in_valid = 1'b0;
      @(negedge c);
      #1 r = 1'b1;
      #1;
      chk("mid_rst_in_ready", int'(in_ready), 0);
      chk("mid_rst_out_valid", int'(out_valid), 0);
      chk("mid_rst_out_q", int'(out_q), 0);
      chk("mid_rst_mx_d", int'(mx_d != '0), 0);
      sb.delete();
      repeat (2) @(negedge c);
      r = 1'b0;
      repeat (30) @(negedge c);
      send_group(tab[0]);
      send_group(tab[3]);
      drain();

      // Backpressure: six full groups against a four-deep FIFO
      or_mode = 1;
      repeat (2) @(negedge c);
`ifdef MAX_GROUP_SCHED_STATS_EN
      base_groups = stat_groups;
`else
      base_groups = '0;
`endif
      fork
         begin
            for (int j = 0; j < 6; j++) send_group(tab[full[j]]);
         end
         begin
            repeat (130) @(negedge c);
            #3;
            chk("stall_in_ready", int'(in_ready), 0);
            chk("stall_out_valid", int'(out_valid), 1);
            chk("stall_head", int'(out_q), int'(tab[full[0]].exp_max));
            chk("stall_queued", sb.size(), 5);
`ifdef MAX_GROUP_SCHED_STATS_EN
            chk("stat_stall_nonzero", int'(stat_stall != 16'd0), 1);
`endif
            or_mode = 0;
         end
      join
      drain();
`ifdef MAX_GROUP_SCHED_STATS_EN
      chk("stat_groups_delta", int'(16'(stat_groups - base_groups)), 6);
`else
      chk("stat_base", int'(base_groups), 0);
`endif

      // Toggling out_ready with back-to-back groups
      or_mode = 2;
      for (int i = 0; i < 10; i++) send_group(tab[i]);
      drain();
      or_mode = 0;
      repeat (5) @(negedge c);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

`default_nettype wire
